// File: rtl/csi_rx_pkt_ctrl_if.sv
// Lane-aligner word bus into, and pixel-word stream out of, the CSI-2 RX packet sequencer.
interface csi_rx_pkt_ctrl_if;
    localparam int unsigned LANES = 4;
    localparam int unsigned DW    = 32;

    logic [LANES-1:0] found_sot;
    logic [LANES-1:0] hs_mode;
    logic [LANES-1:0] byte_gate;
    logic [DW-1:0]    data;
    logic             ecc_ok;

    logic [DW-1:0]    pix_data;
    logic [LANES-1:0] pix_be;
    logic             pix_valid;
    logic             pix_last;

    modport master (
        output found_sot, hs_mode, byte_gate, data, ecc_ok,
        input  pix_data, pix_be, pix_valid, pix_last
    );

    modport slave (
        input  found_sot, hs_mode, byte_gate, data, ecc_ok,
        output pix_data, pix_be, pix_valid, pix_last
    );
endinterface

// File: rtl/csi_rx_pkt_ctrl.sv
// CSI-2 RX packet sequencer: header decode, payload framing, CRC skip and aligner re-arm.
// Optional virtual-channel filter compiled in with CSI_VC_FILTER_EN.
module csi_rx_pkt_ctrl #(
    parameter logic [15:0] MAX_WC  = 16'd8192,
    parameter logic [15:0] TIMEOUT = 16'd1023,
    parameter logic [1:0]  VC_SEL  = 2'd0
) (
    input  logic                clk,
    input  logic                rstn,
    csi_rx_pkt_ctrl_if.slave    bus,
    output logic                frame_start,
    output logic                frame_end,
    output logic                frame_active,
    output logic [15:0]         line_count,
    output logic                err_ecc,
    output logic                err_len,
    output logic                err_trunc,
    output logic                aligner_rst
);
    localparam int unsigned LANES = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned WC_W  = 16;
    localparam int unsigned DT_W  = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PAY,
        S_CRC,
        S_DONE
    } state_t;

    state_t           state, state_d;
    logic [WC_W-1:0]  rem, rem_d;
    logic [WC_W-1:0]  idle_cnt;
    logic [1:0]       wc_lo, wc_lo_d;
    logic             vc_ok, vc_ok_d;

    logic [DW-1:0]    pix_data_d;
    logic [LANES-1:0] pix_be_d;
    logic             pix_valid_d, pix_last_d;
    logic             frame_start_d, frame_end_d, frame_active_d;
    logic [WC_W-1:0]  line_count_d;
    logic             err_ecc_d, err_len_d, err_trunc_d, aligner_rst_d;

    logic             stb_c, hs_all_c, sot_all_c, in_pkt_c, trunc_c, hdr_vc_ok_c;
    logic [DT_W-1:0]  hdr_dt_c;
    logic [WC_W-1:0]  hdr_wc_c;
    logic [WC_W-1:0]  line_inc_c;
    logic [LANES-1:0] tail_be_c;

    assign stb_c     = bus.byte_gate[0];
    assign hs_all_c  = (bus.hs_mode == {LANES{1'b1}});
    assign sot_all_c = (bus.found_sot == {LANES{1'b1}});
    assign hdr_dt_c  = bus.data[5:0];
    assign hdr_wc_c  = bus.data[23:8];
    assign in_pkt_c  = (state == S_HDR) || (state == S_PAY) || (state == S_CRC);
    // An HS drop beats a same-cycle strobe; a strobe beats a same-cycle timeout.
    assign trunc_c   = !hs_all_c || ((idle_cnt >= TIMEOUT) && !stb_c);

`ifdef CSI_VC_FILTER_EN
    logic unused_gate;
    assign hdr_vc_ok_c = (bus.data[7:6] == VC_SEL);
    assign unused_gate = ^bus.byte_gate[3:1];
`else
    logic unused_gate;
    assign hdr_vc_ok_c = 1'b1;
    assign unused_gate = ^{bus.byte_gate[3:1], VC_SEL};
`endif

    assign line_inc_c = (vc_ok && frame_active) ? line_count + WC_W'(1) : line_count;

    // Byte enables for the final, partially filled payload word.
    always_comb begin
        unique case (rem[1:0])
            2'd1:    tail_be_c = 4'b0001;
            2'd2:    tail_be_c = 4'b0011;
            2'd3:    tail_be_c = 4'b0111;
            default: tail_be_c = 4'b1111;
        endcase
    end

    always_comb begin
        state_d        = state;
        rem_d          = rem;
        wc_lo_d        = wc_lo;
        vc_ok_d        = vc_ok;
        pix_data_d     = bus.pix_data;
        pix_be_d       = '0;
        pix_valid_d    = 1'b0;
        pix_last_d     = 1'b0;
        frame_start_d  = 1'b0;
        frame_end_d    = 1'b0;
        frame_active_d = frame_active;
        line_count_d   = line_count;
        err_ecc_d      = 1'b0;
        err_len_d      = 1'b0;
        err_trunc_d    = 1'b0;
        aligner_rst_d  = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (sot_all_c && hs_all_c && stb_c) state_d = S_HDR;
            end
            S_HDR: begin
                if (trunc_c) begin
                    err_trunc_d = 1'b1;
                    state_d     = S_DONE;
                end else if (stb_c) begin
                    vc_ok_d = hdr_vc_ok_c;
                    wc_lo_d = hdr_wc_c[1:0];
                    state_d = S_DONE;
                    if (!bus.ecc_ok) begin
                        err_ecc_d = 1'b1;
                    end else if (hdr_dt_c <= DT_W'(6'h0F)) begin
                        if (hdr_vc_ok_c && hdr_dt_c == DT_W'(0)) begin
                            frame_start_d  = 1'b1;
                            frame_active_d = 1'b1;
                            line_count_d   = '0;
                        end else if (hdr_vc_ok_c && hdr_dt_c == DT_W'(1)) begin
                            frame_end_d    = 1'b1;
                            frame_active_d = 1'b0;
                        end
                    end else if (hdr_wc_c == '0 || hdr_wc_c > MAX_WC) begin
                        err_len_d = 1'b1;
                    end else begin
                        rem_d   = hdr_wc_c;
                        state_d = S_PAY;
                    end
                end
            end
            S_PAY: begin
                if (trunc_c) begin
                    err_trunc_d  = 1'b1;
                    pix_last_d   = vc_ok;
                    line_count_d = line_inc_c;
                    state_d      = S_DONE;
                end else if (stb_c) begin
                    pix_valid_d = vc_ok;
                    if (vc_ok) begin
                        pix_data_d = bus.data;
                        pix_be_d   = (rem > WC_W'(3)) ? 4'b1111 : tail_be_c;
                    end
                    if (rem <= WC_W'(4)) begin
                        pix_last_d   = vc_ok;
                        line_count_d = line_inc_c;
                        // CRC fits in the last word only when 1 or 2 payload bytes are left over.
                        state_d      = (wc_lo == 2'd0 || wc_lo == 2'd3) ? S_CRC : S_DONE;
                    end else begin
                        rem_d = rem - WC_W'(4);
                    end
                end
            end
            S_CRC: begin
                if (trunc_c) begin
                    err_trunc_d = 1'b1;
                    state_d     = S_DONE;
                end else if (stb_c) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!hs_all_c) begin
                    aligner_rst_d = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Inter-strobe watchdog, restarted on every strobe and state change.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idle_cnt <= '0;
        end else if (!in_pkt_c || stb_c || state_d != state) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + WC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= S_IDLE;
            rem           <= '0;
            wc_lo         <= '0;
            vc_ok         <= 1'b0;
            bus.pix_data  <= '0;
            bus.pix_be    <= '0;
            bus.pix_valid <= 1'b0;
            bus.pix_last  <= 1'b0;
            frame_start   <= 1'b0;
            frame_end     <= 1'b0;
            frame_active  <= 1'b0;
            line_count    <= '0;
            err_ecc       <= 1'b0;
            err_len       <= 1'b0;
            err_trunc     <= 1'b0;
            aligner_rst   <= 1'b0;
        end else begin
            state         <= state_d;
            rem           <= rem_d;
            wc_lo         <= wc_lo_d;
            vc_ok         <= vc_ok_d;
            bus.pix_data  <= pix_data_d;
            bus.pix_be    <= pix_be_d;
            bus.pix_valid <= pix_valid_d;
            bus.pix_last  <= pix_last_d;
            frame_start   <= frame_start_d;
            frame_end     <= frame_end_d;
            frame_active  <= frame_active_d;
            line_count    <= line_count_d;
            err_ecc       <= err_ecc_d;
            err_len       <= err_len_d;
            err_trunc     <= err_trunc_d;
            aligner_rst   <= aligner_rst_d;
        end
    end
endmodule

// File: doc/csi_rx_pkt_ctrl.md
# csi_rx_pkt_ctrl

Packet sequencer for the 4-lane MIPI CSI-2 receive path. It sits between the lane aligners (`found_sot`, `byte_gate`, `hs_mode`, 32-bit aligned `data`) and the pixel sink. It checks header ECC (supplied by an external `csi_rx_hdr_ecc` instance), decodes short and long packets, counts payload bytes and skips the CRC. It emits frame/line events and a qualified pixel-word stream, then re-arms the aligners when the HS burst ends.

## Interface
- `MAX_WC`, default 16'd8192: largest legal long-packet word count, in bytes.
- `TIMEOUT`, default 16'd1023: clk cycles allowed between word strobes inside a packet.
- `VC_SEL`, default 2'd0: virtual channel accepted when the VC filter is compiled in.
- `clk`  in  1  system clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `found_sot`  in  4  per-lane SoT found.
- `hs_mode`  in  4  per-lane HS active.
- `byte_gate`  in  4  per-lane word valid; bit 0 is the word strobe `stb`.
- `data`  in  32  aligned word: lane0 = [7:0] … lane3 = [31:24].
- `ecc_ok`  in  1  combinational: ECC over `data[23:0]` equals `data[31:24]`.
- `pix_data`  out  32  payload word.
- `pix_be`  out  4  valid payload bytes in `pix_data`, LSB-first.
- `pix_valid`  out  1  payload word qualifier.
- `pix_last`  out  1  final payload word of the packet.
- `frame_start`, `frame_end`  out  1  one-cycle pulses.
- `frame_active`  out  1  high between FS and FE.
- `line_count`  out  16  long packets completed in the current frame.
- `err_ecc`, `err_len`, `err_trunc`  out  1  one-cycle error pulses.
- `aligner_rst`  out  1  one-cycle re-arm pulse to the lane aligners.

## Operation
- All outputs are 0 at reset.
- One packet per HS burst; any trailing words in the burst are ignored.
- Word count is held in `rem` (16 bit). CRC bytes are never forwarded.
- **IDLE:** if `found_sot`==4'b1111, `hs_mode`==4'b1111 and `stb`, go to HDR.
- **HDR**, on `stb`: latch `dt`=data[5:0], `vc`=data[7:6], `wc`=data[23:8].
  - `!ecc_ok`: pulse `err_ecc`, go to DONE.
  - `dt`≤6'h0F (short packet):
    - `dt`=0: `frame_start`=1, `frame_active`=1, `line_count`=0.
    - `dt`=1: `frame_end`=1, `frame_active`=0.
    - Other short types: ignored.
    - Then go to DONE.
  - Long packet with `wc`=0 or `wc`>`MAX_WC`: pulse `err_len`, go to DONE.
  - Long packet otherwise: `rem`=`wc`, go to PAY.
- **PAY**, on `stb`:
  - `pix_valid`=1, `pix_data`=`data`.
  - `pix_be` = 4'b1111 if `rem`≥4, else the low `rem` bits set.
  - When `rem`≤4: `pix_last`=1. Next state is CRC if `wc[1:0]` is 0 or 3, else DONE.
  - Otherwise `rem`-=4.
  - On PAY exit, if `frame_active`: `line_count`+=1, wrapping 16'hFFFF→0.
- **CRC:** consume one `stb` (the CRC word that did not fit), then go to DONE.
- **DONE:** wait until `hs_mode`!=4'b1111, pulse `aligner_rst`, go to IDLE.
- **Truncation:** in HDR, PAY or CRC, if any `hs_mode` bit drops or the idle counter reaches `TIMEOUT`: pulse `err_trunc`. In PAY also force `pix_last` on the next cycle with `pix_valid`=0. Then go to DONE.

## Timing
- All outputs are registered. `pix_*` and event pulses appear 1 clk after the qualifying `stb`.
- `aligner_rst` asserts 1 clk after HS drops in DONE; IDLE is entered the cycle after.
- The idle counter clears on every `stb` and on state entry. A `stb` and the `TIMEOUT` count in the same cycle: `stb` wins.
- An `hs_mode` drop and a `stb` in the same cycle: the drop wins; the word is discarded.
- Asserting `rstn` mid-packet clears all state immediately. No `aligner_rst` is issued.

## Configuration
- **`CSI_VC_FILTER_EN` defined:** packets whose `vc`!=`VC_SEL` are sequenced normally, with CRC skip, DONE and `aligner_rst`. They produce no `pix_*`, no frame events and no `line_count` change. ECC and length errors still report.
- **`CSI_VC_FILTER_EN` undefined:** all VCs are accepted and `VC_SEL` is unused.

## Test plan
- FS short packet (header 32'hXX000000, `ecc_ok`=1) → `frame_start` pulse, `frame_active`=1, `line_count`=0. HS drop → one `aligner_rst`.
- Long packet `dt`=6'h2A, `wc`=10, 3 payload words → `pix_be` 1111, 1111, 0011; `pix_last` on the 3rd word; no CRC word consumed; `line_count`=1.
- `wc`=8 → 2 pix words, then one CRC `stb` consumed with no `pix_valid`.
- Header with `ecc_ok`=0 → `err_ecc` pulse, no `pix_valid`, `aligner_rst` after HS drop.
- `wc`=16, `hs_mode` drops after 2 words → `err_trunc`, `pix_last` with `pix_valid`=0, `line_count` still incremented.
- No `stb` for 1023 clk in PAY → `err_trunc`. With `CSI_VC_FILTER_EN` and `vc`=1, `VC_SEL`=0 → no pix output, but `aligner_rst` is still issued.
